ysyx_220053_lsu: RTL
====================

YSYX_220053_LSU -- requirements
Module: ysyx_220053_lsu

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the number of cycles (1..15) from the memory-request cycle to the `mem_rdata` capture.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 `clk`  in  1  rising-edge clock.
REQ-004 `rst_n`  in  1  asynchronous active-low reset.
REQ-005 `in_valid`, `in_ready`  in/out  1  EX-side request handshake.
REQ-006 `in_memop`  in  3  [1:0] size (00 word, 01 byte, 10 half, 11 dword); [2] unsigned.
REQ-007 `in_wen`  in  1  1 = store, 0 = load.
REQ-008 `in_addr`, `in_wdata`  in  64  byte address, store data.
REQ-009 `in_rd`  in  5  destination register tag.
REQ-010 `mem_op`  out  3  MemOp to the memory stage.
REQ-011 `mem_addr`, `mem_wdata`  out  64  address and data to the memory stage.
REQ-012 `mem_wen`  out  1  memory write enable.
REQ-013 `mem_rdata`  in  64  extended load data from the memory stage.
REQ-014 `out_valid`, `out_ready`  out/in  1  WB-side response handshake.
REQ-015 `out_data`  out  64  load result; 0 for stores.
REQ-016 `out_rd`  out  5  registered `in_rd`.
REQ-017 `out_misalign`  out  1  access was misaligned.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and RESP; `in_ready` SHALL be 1 only in IDLE.
REQ-019 On `in_valid` && `in_ready` at a rising edge, the block SHALL register memop, wen, addr, wdata and rd, then go to REQ, or to RESP with misalign=1 if misaligned.
REQ-020 An access SHALL be misaligned when: word with addr[1:0]!=0; half with addr[0]!=0; dword with addr[2:0]!=0; byte is never misaligned.
REQ-021 A misaligned access SHALL produce no memory request; `mem_wen` SHALL stay 0 and `out_data` SHALL be 0.
REQ-022 In REQ and WAIT, `mem_op`, `mem_addr` and `mem_wdata` SHALL equal the registered values and stay stable.
REQ-023 In all other states, `mem_op`, `mem_addr` and `mem_wdata` SHALL hold their last values.
REQ-024 `mem_wen` SHALL be 1 for exactly one cycle (REQ) per accepted aligned store and 0 in every other state.
REQ-025 The block SHALL use a 4-bit latency counter, loaded with MEM_LAT-1 on entry to REQ.
REQ-026 In REQ/WAIT, if the counter is 0, the block SHALL capture `mem_rdata` (loads) into `out_data` and go to RESP; otherwise it SHALL decrement and go (or stay) in WAIT.
REQ-027 With MEM_LAT=1, the REQ→RESP transition SHALL be direct, and request-accept to `out_valid` SHALL be 2 cycles.
REQ-028 In RESP, `out_valid` SHALL be 1, and `out_data`, `out_rd` and `out_misalign` SHALL be held stable until `out_ready`; then the block SHALL go to IDLE.
REQ-029 Stores SHALL also return one response, with `out_data`=0, so WB can retire them.
REQ-030 There SHALL be no accept/response overlap: peak throughput SHALL be one access per MEM_LAT+2 cycles.
REQ-031 `in_valid` outside IDLE SHALL be ignored, and the request SHALL not be lost; the upstream holds it per valid/ready.
REQ-032 `out_ready` outside RESP SHALL be ignored.

Reset
REQ-033 On `rst_n`=0, the block SHALL go to IDLE immediately (asynchronously).
REQ-034 On reset, `mem_wen`, `out_valid` and `out_misalign` SHALL go to 0, and all data/address/tag registers and the counter SHALL go to 0.
REQ-035 Reset during REQ/WAIT/RESP SHALL drop the in-flight access, and no write SHALL occur after reset assertion.
REQ-036 After `rst_n` rises, `in_ready`=1 SHALL hold on the first cycle.

Structure
REQ-037 A shared package SHALL hold the state enum, the MemOp size/unsigned constants, and the XLEN=64 constant.
REQ-038 Sub-module ysyx_220053_lsu_align SHALL implement the combinational misalignment check (memop, addr[2:0] -> misalign).

Verification
REQ-039 Load: MEM_LAT=1, lw @0x80000004, `mem_rdata`=0xFFFFFFFF_80000000, `out_ready`=1 -> `out_valid` 2 cycles after accept, `out_data`=0xFFFFFFFF_80000000, `mem_wen` never 1.
REQ-040 Store: sb @0x80000003 data 0xAB -> `mem_wen`=1 for exactly one cycle with `mem_addr`=0x80000003, `mem_op`=3'b001; then response `out_data`=0.
REQ-041 Misalign: lh @0x80000001 -> no REQ cycle, `mem_wen`=0, `out_valid` 1 cycle after accept, `out_misalign`=1.
REQ-042 Backpressure: MEM_LAT=3 ld, `out_ready`=0 for 5 cycles -> `out_valid` held with stable data; `in_ready`=0 throughout; IDLE 1 cycle after `out_ready`.
REQ-043 Reset: `rst_n` low during the REQ cycle of sd -> `mem_wen` falls immediately, no write observed; `in_ready`=1 after release.

Source files
------------

// File: rtl/ysyx_220053_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, MemOp encoding, XLEN.
package ysyx_220053_lsu_pkg;
  localparam int XLEN = 64;

  // MemOp[1:0] is the access size, MemOp[2] selects zero-extension for loads
  localparam logic [1:0] MEMOP_WORD  = 2'b00;
  localparam logic [1:0] MEMOP_BYTE  = 2'b01;
  localparam logic [1:0] MEMOP_HALF  = 2'b10;
  localparam logic [1:0] MEMOP_DWORD = 2'b11;
  localparam int MEMOP_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;
endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Combinational natural-alignment check of an access from its size and low address bits.
module ysyx_220053_lsu_align
  import ysyx_220053_lsu_pkg::*;
(
  input  logic [1:0] memop_size,
  input  logic [2:0] addr_lo,
  output logic       misalign
);

  always_comb begin
    misalign = 1'b0;
    case (memop_size)
      MEMOP_BYTE:  misalign = 1'b0;
      MEMOP_HALF:  misalign = addr_lo[0];
      MEMOP_WORD:  misalign = |addr_lo[1:0];
      MEMOP_DWORD: misalign = |addr_lo;
      default:     misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: accepts one EX request, issues it to memory after an alignment check,
// waits MEM_LAT cycles for the data and returns a single response to WB.
module ysyx_220053_lsu
  import ysyx_220053_lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_memop,
  input  logic            in_wen,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic [2:0]      mem_op,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wen,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_misalign
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  lsu_state_e      state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic [2:0]      mem_op_reg;
  logic [XLEN-1:0] mem_addr_reg, mem_wdata_reg, out_data_reg;
  logic            wen_reg, misalign_reg;
  logic [4:0]      rd_reg;
  logic            in_misalign, accept, lat_done, busy;

  ysyx_220053_lsu_align u_align (
    .memop_size(in_memop[1:0]),
    .addr_lo   (in_addr[2:0]),
    .misalign  (in_misalign)
  );

  assign accept   = in_valid && (state_reg == ST_IDLE);
  assign lat_done = (cnt_reg == 4'd0);
  assign busy     = (state_reg == ST_REQ) || (state_reg == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // mem_wen is decoded from the state so an asynchronous reset kills it at once
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mem_wen    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_misalign ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        mem_wen    = wen_reg;
        state_next = lat_done ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-side registers only move on an aligned accept, so a faulting access
  // leaves the previous request visible on the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      mem_op_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      out_data_reg  <= '0;
      wen_reg       <= 1'b0;
      misalign_reg  <= 1'b0;
      rd_reg        <= '0;
    end else if (accept) begin
      wen_reg      <= in_wen;
      rd_reg       <= in_rd;
      misalign_reg <= in_misalign;
      out_data_reg <= '0;
      if (!in_misalign) begin
        mem_op_reg    <= in_memop;
        mem_addr_reg  <= in_addr;
        mem_wdata_reg <= in_wdata;
        cnt_reg       <= LAT_INIT;
      end
    end else if (busy) begin
      if (lat_done) begin
        if (!wen_reg) out_data_reg <= mem_rdata;
      end else begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  assign mem_op       = mem_op_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign out_data     = out_data_reg;
  assign out_rd       = rd_reg;
  assign out_misalign = misalign_reg;

endmodule
